fpu_addsub_scheduler: RTL

- Shares one pipelined double-precision add/sub datapath (Addition_Subtraction) between NUM_REQ requesters.
- Per cycle: round-robin arbitration over valid requests and one operand issue to the datapath.
- Tracks in-flight operations with a tag pipeline and returns each result and exception flag to the requester that issued it.
- Sits between the FPU front-end issue ports and the shared adder.

---
 rtl/fpu_pkg.sv | 13 +
 rtl/fpu_rr_arbiter.sv | 25 ++
 rtl/fpu_addsub_scheduler.sv | 82 ++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU constants, op encoding and the scheduler tag entry type.
package fpu_pkg;
    localparam int FP_WIDTH = 64;
    localparam int ID_W = 3;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam logic [FP_WIDTH-1:0] POS_INF = 64'h7FF0000000000000;
    localparam logic [FP_WIDTH-1:0] ONE = 64'h3FF0000000000000;
    typedef struct packed {
        logic valid;
        logic [ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter: combinational round-robin grant, searching upward from ptr with wrap.
module fpu_rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);
    int j;
    always_comb begin
        grant = '0;
        idx = '0;
        j = 0;
        // Walk offsets from the far end so the nearest requester to ptr wins last
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j]) begin
                grant = NUM_REQ'(1) << j;
                idx = IW'(j);
            end
        end
    end
endmodule

// File: rtl/fpu_addsub_scheduler.sv
// fpu_addsub_scheduler: shares one pipelined binary64 add/sub datapath among NUM_REQ
// requesters, tagging each issue so its result returns to the requester that sent it.
module fpu_addsub_scheduler
    import fpu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int LATENCY = 2,
    parameter int WIDTH = FP_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_op,
    output logic                     dp_enable,
    output logic [WIDTH-1:0]         dp_a,
    output logic [WIDTH-1:0]         dp_b,
    output logic                     dp_add_or_sub,
    input  logic [WIDTH-1:0]         dp_result,
    input  logic                     dp_exception,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_exception,
    output logic                     busy
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      idx;
    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    tag_t               tags [LATENCY+1];
    tag_t               last;

    fpu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx)
    );

    // Grant implies valid, so any ready bit is a transfer
    assign req_ready = reset ? '0 : grant;
    assign xfer = |req_ready;
    assign last = tags[LATENCY];
    assign dp_enable = xfer | busy;

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= LATENCY; k++) busy = busy | tags[k].valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            dp_a <= '0;
            dp_b <= '0;
            dp_add_or_sub <= 1'b0;
            rsp_valid <= '0;
            rsp_result <= '0;
            rsp_exception <= 1'b0;
            for (int k = 0; k <= LATENCY; k++) tags[k] <= '0;
        end else begin
            if (xfer) begin
                ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
                dp_a <= req_a[idx*WIDTH +: WIDTH];
                dp_b <= req_b[idx*WIDTH +: WIDTH];
                dp_add_or_sub <= req_op[idx];
            end
            tags[0] <= '{valid: xfer, id: ID_W'(idx)};
            for (int k = 1; k <= LATENCY; k++) tags[k] <= tags[k-1];
            rsp_valid <= last.valid ? NUM_REQ'(1) << last.id : '0;
            // Result registers hold between responses
            if (last.valid) begin
                rsp_result <= dp_result;
                rsp_exception <= dp_exception;
            end
        end
    end
endmodule
